// File: rtl/rdma_pkg.sv
// Shared constants for the RDMA packet router: header field offsets,
// protocol/magic values and input FSM state encodings.
package rdma_pkg;

  localparam logic [15:0] RDMA_MAGIC  = 16'h0122;
  localparam int          PROT_OFS    = 23;
  localparam int          UDP_DST_OFS = 36;
  localparam int          MAGIC_OFS   = 42;
  localparam logic [7:0]  IP_PROT_UDP = 8'd17;

  localparam logic [1:0] ST_STARTING = 2'd0;
  localparam logic [1:0] ST_HDR      = 2'd1;
  localparam logic [1:0] ST_PASS     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rdma_pkt_router_skid_buffer.sv
// Registered 2-entry AXI-Stream slice (module axis_skid_buffer); ready is a
// pure register output so the upstream never sees out_ready combinationally.
module axis_skid_buffer #(
  parameter int DATA_WBITS = 512,
  parameter int USER_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WBITS-1:0]   in_data,
  input  logic [DATA_WBITS/8-1:0] in_keep,
  input  logic [USER_BITS-1:0]    in_user,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WBITS-1:0]   out_data,
  output logic [DATA_WBITS/8-1:0] out_keep,
  output logic [USER_BITS-1:0]    out_user,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int KEEP_BITS = DATA_WBITS / 8;
  localparam int PAY_BITS  = DATA_WBITS + KEEP_BITS + USER_BITS + 1;

  logic [PAY_BITS-1:0] in_pay;
  logic [PAY_BITS-1:0] out_pay_reg;
  logic [PAY_BITS-1:0] skid_pay_reg;
  logic                out_valid_reg;
  logic                skid_valid_reg;
  logic                in_fire;
  logic                out_free;

  assign in_pay   = {in_data, in_keep, in_user, in_last};
  assign in_ready = ~skid_valid_reg;
  assign in_fire  = in_valid & ~skid_valid_reg;
  assign out_free = ~out_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_pay_reg    <= '0;
      skid_pay_reg   <= '0;
    end else if (out_free) begin
      // A parked beat always drains before new input (ready was low meanwhile).
      if (skid_valid_reg) begin
        out_pay_reg    <= skid_pay_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= in_fire;
        if (in_fire) begin
          out_pay_reg <= in_pay;
        end
      end
    end else if (in_fire) begin
      skid_pay_reg   <= in_pay;
      skid_valid_reg <= 1'b1;
    end
  end

  assign {out_data, out_keep, out_user, out_last} = out_pay_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: rtl/rdma_pkt_router.sv
// RDMA packet router: classifies each packet on its first-beat header and
// forwards matches tagged with the port index. Statistics need RDMA_ROUTER_STATS_EN.
module rdma_pkt_router
  import rdma_pkg::*;
#(
  parameter int                      DATA_WBITS   = 512,
  parameter int                      DATA_WBYTS   = DATA_WBITS / 8,
  parameter int                      NUM_PORTS    = 4,
  parameter int                      CH_BITS      = 3,
  parameter logic [16*NUM_PORTS-1:0] SERVER_PORTS = {16'd32005, 16'd32004, 16'd32003, 16'd32002},
  parameter logic [15:0]             RDMA_MAGIC   = rdma_pkg::RDMA_MAGIC
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_PORTS-1:0]  cfg_port_en,
  input  logic                  stat_clear,
  input  logic [DATA_WBITS-1:0] AXIS_IN_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN_TKEEP,
  input  logic                  AXIS_IN_TVALID,
  input  logic                  AXIS_IN_TLAST,
  output logic                  AXIS_IN_TREADY,
  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
  output logic [CH_BITS-1:0]    AXIS_OUT_TUSER,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  input  logic                  AXIS_OUT_TREADY,
  output logic [31:0]           stat_accept,
  output logic [31:0]           stat_drop
);

  logic [7:0]           hdr_prot;
  logic [15:0]          hdr_dport;
  logic [15:0]          hdr_magic;
  logic [NUM_PORTS-1:0] port_hit;
  logic [CH_BITS-1:0]   hit_idx;
  logic                 hdr_accept;

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic [CH_BITS-1:0]   port_idx_reg;
  logic                 skid_ready;
  logic                 skid_valid;
  logic [CH_BITS-1:0]   skid_user;
  logic                 in_fire;
  logic                 hdr_fire;

  // Wire order is little-endian; multi-byte header fields are big-endian.
  assign hdr_prot  = AXIS_IN_TDATA[8*PROT_OFS +: 8];
  assign hdr_dport = {AXIS_IN_TDATA[8*UDP_DST_OFS +: 8], AXIS_IN_TDATA[8*(UDP_DST_OFS+1) +: 8]};
  assign hdr_magic = {AXIS_IN_TDATA[8*MAGIC_OFS +: 8], AXIS_IN_TDATA[8*(MAGIC_OFS+1) +: 8]};

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_hit[gi] = cfg_port_en[gi] && (hdr_dport == SERVER_PORTS[16*gi +: 16]);
    end
  endgenerate

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_hit[i]) begin
        hit_idx = CH_BITS'(i);
      end
    end
  end

  assign hdr_accept = (hdr_prot == IP_PROT_UDP) && (hdr_magic == RDMA_MAGIC) && (|port_hit);

  always_comb begin
    AXIS_IN_TREADY = 1'b0;
    case (state_reg)
      ST_STARTING: AXIS_IN_TREADY = 1'b0;
      ST_DROP:     AXIS_IN_TREADY = 1'b1;
      default:     AXIS_IN_TREADY = skid_ready;
    endcase
  end

  assign in_fire    = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign hdr_fire   = in_fire && (state_reg == ST_HDR);
  assign skid_valid = AXIS_IN_TVALID &&
                      (((state_reg == ST_HDR) && hdr_accept) || (state_reg == ST_PASS));
  assign skid_user  = (state_reg == ST_HDR) ? hit_idx : port_idx_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STARTING: state_next = ST_HDR;
      ST_HDR: begin
        if (in_fire && !AXIS_IN_TLAST) begin
          state_next = hdr_accept ? ST_PASS : ST_DROP;
        end
      end
      default: begin
        if (in_fire && AXIS_IN_TLAST) begin
          state_next = ST_HDR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_STARTING;
      port_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (hdr_fire) begin
        port_idx_reg <= hit_idx;
      end
    end
  end

  axis_skid_buffer #(
    .DATA_WBITS (DATA_WBITS),
    .USER_BITS  (CH_BITS)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (AXIS_IN_TDATA),
    .in_keep   (AXIS_IN_TKEEP),
    .in_user   (skid_user),
    .in_last   (AXIS_IN_TLAST),
    .in_valid  (skid_valid),
    .in_ready  (skid_ready),
    .out_data  (AXIS_OUT_TDATA),
    .out_keep  (AXIS_OUT_TKEEP),
    .out_user  (AXIS_OUT_TUSER),
    .out_last  (AXIS_OUT_TLAST),
    .out_valid (AXIS_OUT_TVALID),
    .out_ready (AXIS_OUT_TREADY)
  );

`ifdef RDMA_ROUTER_STATS_EN
  logic [31:0] accept_cnt_reg;
  logic [31:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn || stat_clear) begin
      accept_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else if (hdr_fire) begin
      if (hdr_accept) begin
        accept_cnt_reg <= sat_inc(accept_cnt_reg);
      end else begin
        drop_cnt_reg <= sat_inc(drop_cnt_reg);
      end
    end
  end

  assign stat_accept = accept_cnt_reg;
  assign stat_drop   = drop_cnt_reg;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_accept       = '0;
  assign stat_drop         = '0;
`endif

endmodule

// File: tb/tb_rdma_pkt_router.sv
// Self-checking bench for rdma_pkt_router: vector table, directed corner
// sequences and a randomized run against a byte-level reference model.
module tb_rdma_pkt_router;

  localparam int DW = 512;
  localparam int KB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KB-1:0] keep;
    logic          last;
    logic [2:0]    user;
  } beat_t;

  typedef struct {
    int         prot;
    int         port;
    int         magic;
    logic [3:0] en;
    int         nbeats;
    int         exp_idx;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    cfg_port_en = 4'h0;
  logic          stat_clear = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic [KB-1:0] in_tkeep = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic [KB-1:0] out_tkeep;
  logic [2:0]    out_tuser;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready = 1'b0;
  logic [31:0]   stat_accept;
  logic [31:0]   stat_drop;

  int            checks = 0;
  int            errors = 0;
  int            out_beats = 0;
  int            cycle_cnt = 0;
  int            pkt_no = 0;
  bit            rand_ready = 1'b0;
  bit            fixed_ready = 1'b0;
  logic [31:0]   exp_acc = '0;
  logic [31:0]   exp_drp = '0;
  beat_t         exp_q[$];
  vec_t          vecs[9];

  rdma_pkt_router dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg_port_en     (cfg_port_en),
    .stat_clear      (stat_clear),
    .AXIS_IN_TDATA   (in_tdata),
    .AXIS_IN_TKEEP   (in_tkeep),
    .AXIS_IN_TVALID  (in_tvalid),
    .AXIS_IN_TLAST   (in_tlast),
    .AXIS_IN_TREADY  (in_tready),
    .AXIS_OUT_TDATA  (out_tdata),
    .AXIS_OUT_TKEEP  (out_tkeep),
    .AXIS_OUT_TUSER  (out_tuser),
    .AXIS_OUT_TVALID (out_tvalid),
    .AXIS_OUT_TLAST  (out_tlast),
    .AXIS_OUT_TREADY (out_tready),
    .stat_accept     (stat_accept),
    .stat_drop       (stat_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
  end

  always @(posedge clk) begin
    #1;
    out_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: sampled mid-cycle, a beat transfers on the next rising edge.
  always @(negedge clk) begin
    if (resetn && out_tvalid && out_tready) begin
      beat_t e;
      out_beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got user=%0d last=%0b expected no beat", out_tuser, out_tlast);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_tdata, e.data);
        check("out_keep", DW'(out_tkeep), DW'(e.keep));
        check("out_last", DW'(out_tlast), DW'(e.last));
        check("out_user", DW'(out_tuser), DW'(e.user));
      end
    end
  end

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] make_hdr(input int prot, input int port, input int magic);
    logic [DW-1:0] d;
    logic [15:0]   p;
    logic [15:0]   m;
    d = rand512();
    p = 16'(port);
    m = 16'(magic);
    d[8*23 +: 8] = 8'(prot);
    d[8*36 +: 8] = p[15:8];
    d[8*37 +: 8] = p[7:0];
    d[8*42 +: 8] = m[15:8];
    d[8*43 +: 8] = m[7:0];
    return d;
  endfunction

  // Reference classification: read fields as network-order bytes, table entry i is port 32002+i.
  function automatic int ref_route(input logic [DW-1:0] hdr, input logic [3:0] en);
    int prot;
    int dport;
    int magic;
    prot  = int'(hdr[8*23 +: 8]);
    dport = int'(hdr[8*36 +: 8]) * 256 + int'(hdr[8*37 +: 8]);
    magic = int'(hdr[8*42 +: 8]) * 256 + int'(hdr[8*43 +: 8]);
    if (prot != 17 || magic != 'h0122) return -1;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && dport == 32002 + i) return i;
    end
    return -1;
  endfunction

  // Called and returns at rising edge + 2.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    in_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_tready) begin
        @(posedge clk);
        #2;
        in_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    errors++;
    $display("FAIL in_handshake_timeout: got no TREADY in 1000 cycles, required a handshake");
    in_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input int nbeats, input logic [3:0] en,
                          input int exp_idx, input int gap_max);
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    cfg_port_en = en;
    for (int b = 0; b < nbeats; b++) begin
      d = (b == 0) ? hdr : rand512();
      l = (b == nbeats - 1);
      k = l ? ({$urandom, $urandom} | 64'd1) : '1;
      if (exp_idx >= 0) exp_q.push_back('{data: d, keep: k, last: l, user: 3'(exp_idx)});
      drive_beat(d, k, l);
      if (b == 0) cfg_port_en = 4'($urandom);
      for (int g = 0; g < $urandom_range(0, gap_max); g++) begin
        @(posedge clk);
        #2;
      end
    end
    if (exp_idx >= 0) begin
      if (exp_acc != 32'hFFFF_FFFF) exp_acc++;
    end else begin
      if (exp_drp != 32'hFFFF_FFFF) exp_drp++;
    end
    pkt_no++;
    $display("pkt %0d: beats=%0d route=%0d exp_accept=%0d exp_drop=%0d", pkt_no, nbeats, exp_idx, exp_acc, exp_drp);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    check("drain_pending", DW'(exp_q.size()), '0);
  endtask

  task automatic check_stats();
`ifdef RDMA_ROUTER_STATS_EN
    check("stat_accept", DW'(stat_accept), DW'(exp_acc));
    check("stat_drop", DW'(stat_drop), DW'(exp_drp));
`else
    check("stat_accept", DW'(stat_accept), '0);
    check("stat_drop", DW'(stat_drop), '0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int c0;
    logic [DW-1:0] h;

    vecs[0] = '{prot: 17, port: 32003, magic: 'h0122, en: 4'hF, nbeats: 3, exp_idx: 1};
    vecs[1] = '{prot: 17, port: 32003, magic: 'h0122, en: 4'hD, nbeats: 3, exp_idx: -1};
    vecs[2] = '{prot: 17, port: 32002, magic: 'h0122, en: 4'hF, nbeats: 2, exp_idx: 0};
    vecs[3] = '{prot: 17, port: 32005, magic: 'h0122, en: 4'h8, nbeats: 1, exp_idx: 3};
    vecs[4] = '{prot: 17, port: 32004, magic: 'h0122, en: 4'hB, nbeats: 2, exp_idx: -1};
    vecs[5] = '{prot: 6,  port: 32003, magic: 'h0122, en: 4'hF, nbeats: 2, exp_idx: -1};
    vecs[6] = '{prot: 17, port: 32003, magic: 'h0123, en: 4'hF, nbeats: 2, exp_idx: -1};
    vecs[7] = '{prot: 17, port: 32002, magic: 'h0122, en: 4'h6, nbeats: 1, exp_idx: -1};
    vecs[8] = '{prot: 17, port: 32004, magic: 'h0122, en: 4'hC, nbeats: 4, exp_idx: 2};

    // Reset state.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_in_tready", DW'(in_tready), '0);
    check("rst_out_tvalid", DW'(out_tvalid), '0);
    check("rst_out_tuser", DW'(out_tuser), '0);
    check("rst_stat_accept", DW'(stat_accept), '0);
    check("rst_stat_drop", DW'(stat_drop), '0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    fixed_ready = 1'b1;
    @(negedge clk);
    check("starting_in_tready", DW'(in_tready), '0);
    @(negedge clk);
    check("hdr_in_tready", DW'(in_tready), 1);
    @(posedge clk);
    #2;

    // Vector table, output always ready: every packet at one beat per cycle.
    foreach (vecs[v]) begin
      b0 = out_beats;
      c0 = cycle_cnt;
      send_pkt(make_hdr(vecs[v].prot, vecs[v].port, vecs[v].magic), vecs[v].nbeats,
               vecs[v].en, vecs[v].exp_idx, 0);
      check("vec_cycles", DW'(cycle_cnt - c0), DW'(vecs[v].nbeats));
      wait_drain();
      check("vec_beats_out", DW'(out_beats - b0), DW'((vecs[v].exp_idx >= 0) ? vecs[v].nbeats : 0));
      check_stats();
    end

    // Reject drained at line rate while output is stalled; next packet parks.
    fixed_ready = 1'b0;
    @(posedge clk);
    #2;
    b0 = out_beats;
    c0 = cycle_cnt;
    send_pkt(make_hdr(6, 32003, 'h0122), 5, 4'hF, -1, 0);
    check("drop_stalled_cycles", DW'(cycle_cnt - c0), 5);
    send_pkt(make_hdr(17, 32002, 'h0122), 1, 4'hF, 0, 0);
    @(negedge clk);
    check("latency_out_tvalid", DW'(out_tvalid), 1);
    repeat (5) @(negedge clk);
    check("held_out_tvalid", DW'(out_tvalid), 1);
    check("held_no_transfer", DW'(out_beats - b0), '0);
    @(posedge clk);
    #2;
    fixed_ready = 1'b1;
    wait_drain();
    check("released_beats", DW'(out_beats - b0), 1);
    check_stats();

    // Back-to-back single-beat packets.
    b0 = out_beats;
    c0 = cycle_cnt;
    send_pkt(make_hdr(17, 32004, 'h0122), 1, 4'hF, 2, 0);
    send_pkt(make_hdr(17, 32005, 'h0122), 1, 4'hF, 3, 0);
    check("b2b_cycles", DW'(cycle_cnt - c0), 2);
    wait_drain();
    check("b2b_beats", DW'(out_beats - b0), 2);
    check_stats();

`ifdef RDMA_ROUTER_STATS_EN
    // Saturation at the counter maximum.
    @(negedge clk);
    force dut.accept_cnt_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.accept_cnt_reg;
    @(posedge clk);
    #2;
    exp_acc = 32'hFFFF_FFFF;
    send_pkt(make_hdr(17, 32003, 'h0122), 2, 4'hF, 1, 0);
    wait_drain();
    check_stats();
`endif

    // Clear pulse coincident with an accepted header: clear wins.
    h = make_hdr(17, 32003, 'h0122);
    exp_q.push_back('{data: h, keep: '1, last: 1'b1, user: 3'd1});
    cfg_port_en = 4'hF;
    in_tdata = h;
    in_tkeep = '1;
    in_tlast = 1'b1;
    in_tvalid = 1'b1;
    stat_clear = 1'b1;
    @(negedge clk);
    check("clear_coincident_tready", DW'(in_tready), 1);
    @(posedge clk);
    #2;
    in_tvalid = 1'b0;
    stat_clear = 1'b0;
    exp_acc = '0;
    exp_drp = '0;
    wait_drain();
    check_stats();

    // Randomized mixed traffic with 50% output back-pressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int prot;
      int port;
      int magic;
      logic [3:0] en;
      prot  = ($urandom_range(0, 4) == 0) ? 6 : 17;
      port  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535)) : 32002 + int'($urandom_range(0, 4));
      magic = ($urandom_range(0, 4) == 0) ? 'h0123 : 'h0122;
      en    = 4'($urandom);
      h     = make_hdr(prot, port, magic);
      send_pkt(h, $urandom_range(1, 4), en, ref_route(h, en), 1);
    end
    wait_drain();
    check_stats();
    rand_ready = 1'b0;
    fixed_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end

    // Reset in the middle of an accepted packet.
    cfg_port_en = 4'hF;
    drive_beat(make_hdr(17, 32003, 'h0122), '1, 1'b0);
    @(negedge clk);
    check("midpkt_out_tvalid_before", DW'(out_tvalid), 1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    exp_acc = '0;
    exp_drp = '0;
    @(posedge clk);
    @(negedge clk);
    check("midpkt_rst_out_tvalid", DW'(out_tvalid), '0);
    check("midpkt_rst_in_tready", DW'(in_tready), '0);
    check_stats();
    @(posedge clk);
    #2;
    resetn = 1'b1;
    fixed_ready = 1'b1;
    b0 = out_beats;
    send_pkt(make_hdr(0, 0, 0), 2, 4'hF, -1, 0);
    send_pkt(make_hdr(17, 32002, 'h0122), 2, 4'hF, 0, 0);
    wait_drain();
    check("after_reset_beats", DW'(out_beats - b0), 2);
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
